// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst reader and its output buffer.
package fifo_rd_pkg;

  localparam int unsigned FifoWidthDef = 16;
  localparam int unsigned BufDepth     = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register buffer; entry 0 is always the head presented on data.
module stream_buf2
  import fifo_rd_pkg::*;
#(
  parameter int unsigned Width = FifoWidthDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  output logic             valid,
  output logic [Width-1:0] data,
  input  logic             pop,
  output logic [1:0]       count
);

  logic [Width-1:0] ent0_q, ent0_d;
  logic [Width-1:0] ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_ok;

  assign pop_ok = pop && (cnt_q != 2'd0);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({wr_en, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = wr_data;
        else               ent1_d = wr_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          ent0_d = wr_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign data  = ent0_q;
  assign count = cnt_q;

  count_in_range: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= 2'(BufDepth));

  no_write_when_full: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !pop_ok && (cnt_q == 2'(BufDepth))));

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a fixed-length burst from a 1-cycle-latency FIFO onto a valid/ready stream.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FifoWidthDef,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  err_underflow
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] reads_left_q, reads_left_d;
  logic [LEN_W-1:0] sent_cnt_q, sent_cnt_d;
  logic             inflight_q;
  logic             err_q, err_d;

  logic [1:0]       buf_cnt;
  logic [2:0]       occ;
  logic [LEN_W-1:0] last_idx;
  logic             pop;

  stream_buf2 #(
    .Width (FIFO_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_q),
    .wr_data (fifo_data_out),
    .valid   (m_valid),
    .data    (m_data),
    .pop     (pop),
    .count   (buf_cnt)
  );

  assign pop      = m_valid && m_ready;
  assign last_idx = len_q - LEN_W'(1);
  // Projected occupancy: buffered words plus the read in flight, less the word leaving now.
  assign occ      = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};

  assign fifo_rd_en = (state_q == StRun) && !fifo_empty && (reads_left_q != '0) &&
                      (occ < 3'd2);

  assign busy          = (state_q == StRun);
  assign done          = (state_q == StDone);
  assign m_last        = m_valid && (sent_cnt_q == last_idx);
  assign err_underflow = err_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    reads_left_d = reads_left_q;
    sent_cnt_d   = sent_cnt_q;
    err_d        = err_q;
    if ((state_q == StRun) && fifo_underflow) err_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (xfer_len != '0) begin
            len_d        = xfer_len;
            reads_left_d = xfer_len;
            sent_cnt_d   = '0;
            state_d      = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (fifo_rd_en) reads_left_d = reads_left_q - LEN_W'(1);
        if (pop) begin
          sent_cnt_d = sent_cnt_q + LEN_W'(1);
          if (sent_cnt_q == last_idx) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      reads_left_q <= '0;
      sent_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      reads_left_q <= reads_left_d;
      sent_cnt_q   <= sent_cnt_d;
      inflight_q   <= fifo_rd_en;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT, a monitor checks the stream.
module tb_fifo_burst_reader;

  localparam int W  = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] xfer_len = '0;
  logic          busy, done, fifo_rd_en, m_valid, m_last, err_underflow;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_underflow;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .FIFO_WIDTH (W),
    .LEN_W      (LW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .xfer_len       (xfer_len),
    .busy           (busy),
    .done           (done),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .err_underflow  (err_underflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: depth 8, registered read data and empty flag.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] wr_pend[$];
  logic         uf_r = 1'b0;
  logic         force_uf = 1'b0;
  assign fifo_underflow = uf_r | force_uf;

  always @(posedge clk) begin
    uf_r <= 1'b0;
    if (fifo_rd_en) begin
      if (fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
      else                   uf_r <= 1'b1;
    end
    while (wr_pend.size() > 0 && fifo_q.size() < 8) fifo_q.push_back(wr_pend.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Sink ready pattern: 0 = always ready, 1 = alternate, 2 = random.
  int ready_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int rd_acc = 0;
  int pops = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      rd_acc = 0;
      pops   = 0;
    end else begin
      if (fifo_rd_en)         rd_acc++;
      if (m_valid && m_ready) pops++;
    end
  end

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;
  exp_t         exp_q[$];
  logic [W-1:0] ref_q[$];
  logic [W-1:0] hold_q[$];

  logic         stall_q = 1'b0;
  logic [W-1:0] held_q = '0;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (stall_q) begin
        check("stall_valid_hold", m_valid, 1'b1);
        check("stall_data_hold", m_data, held_q);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", m_data, 32'hdead_beef);
        end else begin
          e = exp_q.pop_front();
          check("word_data", m_data, e.data);
          check("word_last", m_last, e.last);
        end
      end
      if (fifo_rd_en) check("rd_en_while_empty", fifo_empty, 1'b0);
      if (rd_acc - pops > 2) check("outstanding_le_2", rd_acc - pops, 2);
      stall_q = m_valid && !m_ready;
      held_q  = m_data;
    end
  end

  task automatic push_word(input logic [W-1:0] w, input bit now);
    ref_q.push_back(w);
    if (now) wr_pend.push_back(w);
    else     hold_q.push_back(w);
  endtask

  task automatic do_start(input int len);
    @(posedge clk);
    #1;
    start    = 1'b1;
    xfer_len = LW'(len);
    for (int i = 0; i < len; i++) exp_q.push_back({ref_q.pop_front(), 1'(i == len - 1)});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < max) begin
      @(negedge clk);
      if (done) seen = 1;
      n++;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_rd_en"}, fifo_rd_en, 1'b0);
    check({name, "_m_valid"}, m_valid, 1'b0);
    check({name, "_m_last"}, m_last, 1'b0);
    check({name, "_err"}, err_underflow, 1'b0);
    check({name, "_m_data"}, m_data, '0);
  endtask

  initial begin
    logic [8:0] rd_v, val_v, busy_v, done_v, last_v;
    int         r0, d0, n;
    bit         all_busy;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic 5-word burst with fixed data and exact cycle timing.
    ready_mode = 0;
    for (int i = 1; i <= 5; i++) push_word(W'(i), 1'b1);
    repeat (3) @(posedge clk);
    r0 = rd_acc;
    do_start(5);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      rd_v[k]   = fifo_rd_en;
      val_v[k]  = m_valid;
      busy_v[k] = busy;
      done_v[k] = done;
      last_v[k] = m_last;
    end
    check("t1_rd_en_pattern", rd_v, 9'b0_0001_1111);
    check("t1_valid_pattern", val_v, 9'b0_0111_1100);
    check("t1_busy_pattern", busy_v, 9'b0_0111_1111);
    check("t1_done_pattern", done_v, 9'b0_1000_0000);
    check("t1_last_pattern", last_v, 9'b0_0100_0000);
    check("t1_reads", rd_acc - r0, 5);
    check("t1_drained", exp_q.size(), 0);

    // Zero-length transfer: immediate done, no reads.
    do_start(0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rd_v[k]  = fifo_rd_en;
      val_v[k] = m_valid;
      done_v[k] = done;
      busy_v[k] = busy;
    end
    check("t2_done_pattern", done_v[3:0], 4'b0001);
    check("t2_no_rd_en", rd_v[3:0], 4'b0000);
    check("t2_no_valid", val_v[3:0], 4'b0000);
    check("t2_no_busy", busy_v[3:0], 4'b0000);

    // Eight words with an alternating sink.
    for (int i = 0; i < 8; i++) push_word(W'($urandom), 1'b1);
    repeat (3) @(posedge clk);
    r0 = rd_acc;
    #1 m_ready = 1'b1;
    ready_mode = 1;
    do_start(8);
    wait_done(100, "t3_done_seen");
    check("t3_reads", rd_acc - r0, 8);
    check("t3_fifo_empty", fifo_q.size(), 0);
    check("t3_drained", exp_q.size(), 0);
    ready_mode = 0;

    // FIFO runs dry mid-transfer; the rest arrives 10 cycles later.
    push_word(W'($urandom), 1'b1);
    push_word(W'($urandom), 1'b1);
    push_word(W'($urandom), 1'b0);
    push_word(W'($urandom), 1'b0);
    repeat (3) @(posedge clk);
    r0 = rd_acc;
    d0 = done_cnt;
    do_start(4);
    all_busy = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) all_busy = 0;
    end
    check("t4_busy_while_waiting", all_busy, 1'b1);
    check("t4_reads_while_waiting", rd_acc - r0, 2);
    while (hold_q.size() > 0) wr_pend.push_back(hold_q.pop_front());
    wait_done(50, "t4_done_seen");
    repeat (3) @(negedge clk);
    check("t4_done_once", done_cnt - d0, 1);
    check("t4_drained", exp_q.size(), 0);

    // Reset after 3 of 6 words.
    for (int i = 0; i < 6; i++) push_word(W'($urandom), 1'b1);
    repeat (3) @(posedge clk);
    d0 = pops;
    do_start(6);
    n = 0;
    while (pops - d0 < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_three_popped", pops - d0 >= 3, 1'b1);
    d0  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_after_rst");
    exp_q.delete();
    ref_q.delete();
    wr_pend.delete();
    fifo_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    push_word(W'($urandom), 1'b1);
    push_word(W'($urandom), 1'b1);
    repeat (3) @(posedge clk);
    do_start(2);
    wait_done(30, "t5_restart_done");
    check("t5_restart_drained", exp_q.size(), 0);

    // Underflow flag is sticky through done and cleared by the next start.
    for (int i = 0; i < 3; i++) push_word(W'($urandom), 1'b1);
    repeat (3) @(posedge clk);
    do_start(3);
    force_uf = 1'b1;
    @(posedge clk);
    #1 force_uf = 1'b0;
    wait_done(30, "t6_done_seen");
    check("t6_err_at_done", err_underflow, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_err_held", err_underflow, 1'b1);
    check("t6_drained", exp_q.size(), 0);
    push_word(W'($urandom), 1'b1);
    repeat (3) @(posedge clk);
    do_start(1);
    @(negedge clk);
    check("t6_err_cleared", err_underflow, 1'b0);
    wait_done(30, "t6_second_done");

    // Random lengths and data with a random sink.
    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) push_word(W'($urandom), 1'b1);
      repeat (3) @(posedge clk);
      r0 = rd_acc;
      do_start(n);
      wait_done(200, "rand_done_seen");
      check("rand_reads", rd_acc - r0, n);
      check("rand_drained", exp_q.size(), 0);
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
